// File: rtl/bcd2bin.sv
// Sequential three-digit BCD to 9-bit binary converter using reverse double-dabble.
// One conversion per 11 cycles; results are strobed for a single cycle with an error flag.
module bcd2bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_hundred,
  input  logic [3:0] in_ten,
  input  logic [3:0] in_unit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [8:0] out_bin,
  output logic       out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SHIFT = 4'd8;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] bcd;
  logic [10:0] bcd_nxt;
  logic [8:0]  bin;
  logic [8:0]  bin_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        err;
  logic        err_nxt;
  logic [19:0] shifted;

  // Undo one doubling step of a BCD digit: a digit that reached 8 or more after
  // the right shift received a carried half-ten and must drop back by 3.
  function automatic logic [3:0] digit_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  function automatic logic digits_illegal(input logic [2:0] h,
                                          input logic [3:0] t,
                                          input logic [3:0] u);
    logic [7:0] tens_units;
    tens_units = ({4'd0, t} * 8'd10) + {4'd0, u};
    return (h > 3'd5) || (t > 4'd9) || (u > 4'd9) ||
           ((h == 3'd5) && (tens_units > 8'd11));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcd   <= '0;
      bin   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      bcd   <= bcd_nxt;
      bin   <= bin_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd;
    bin_nxt   = bin;
    cnt_nxt   = cnt;
    err_nxt   = err;
    shifted   = {bcd, bin} >> 1;
    case (state)
      IDLE: begin
        if (in_valid) begin
          bcd_nxt   = {in_hundred, in_ten, in_unit};
          bin_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = digits_illegal(in_hundred, in_ten, in_unit);
          state_nxt = CALC;
        end
      end
      CALC: begin
        // The zero-extended hundreds field is at most 3 after a shift, so it
        // never needs the correction and passes straight through.
        bcd_nxt = {shifted[19:17], digit_fix(shifted[16:13]), digit_fix(shifted[12:9])};
        bin_nxt = shifted[8:0];
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_SHIFT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so nothing from the inputs reaches them
  // combinationally and they read zero whenever no result is being presented.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_err   = (state == DONE) && err;
  assign out_bin   = ((state == DONE) && !err) ? bin : 9'd0;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin against an arithmetic reference of 100*H+10*T+U
// with range/digit legality, covering latency, back-to-back, held valid and reset abort.
module tb_bcd2bin;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_hundred;
  logic [3:0] in_ten;
  logic [3:0] in_unit;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_bin;
  logic       out_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bcd2bin dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_hundred (in_hundred),
    .in_ten     (in_ten),
    .in_unit    (in_unit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bin    (out_bin),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_val(input int h, input int t, input int u);
    return 100 * h + 10 * t + u;
  endfunction

  function automatic bit ref_err(input int h, input int t, input int u);
    return (h > 5) || (t > 9) || (u > 9) || (ref_val(h, t, u) > 511);
  endfunction

  function automatic int ref_bin(input int h, input int t, input int u);
    return ref_err(h, t, u) ? 0 : ref_val(h, t, u);
  endfunction

  // Drives one conversion and reports what came back; callers do the comparisons.
  task automatic run_one(input int h, input int t, input int u,
                         output int got_bin, output bit got_err, output int lat,
                         output bit side_ok, output int acc_cyc);
    int guard;
    side_ok = 1'b1;
    lat     = -1;
    got_bin = 0;
    got_err = 1'b0;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid   = 1'b1;
    in_hundred = h[2:0];
    in_ten     = t[3:0];
    in_unit    = u[3:0];
    acc_cyc    = cyc;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat     = k;
        got_bin = int'(out_bin);
        got_err = out_err;
        if (in_ready !== 1'b0) side_ok = 1'b0;
        break;
      end
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bin !== 9'd0 || out_err !== 1'b0)
        side_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_hundred = '0;
    in_ten     = '0;
    in_unit    = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_bin !== 9'd0) begin failures++; $display("FAIL reset_out_bin got=%0d exp=0", out_bin); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int b, l, a;
    bit e, s;
    run_one(0, 0, 0, b, e, l, s, a);
    checks++; if (b !== 0) begin failures++; $display("FAIL zero_bin got=%0d exp=0", b); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", e); end
    checks++; if (l !== 10) begin failures++; $display("FAIL zero_latency got=%0d exp=10", l); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL zero_quiet_while_busy got=%b exp=1", s); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_strobe got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_done got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int b1, l1, a1, b2, l2, a2;
    bit e1, s1, e2, s2;
    run_one(1, 2, 3, b1, e1, l1, s1, a1);
    run_one(5, 1, 1, b2, e2, l2, s2, a2);
    checks++; if (b1 !== 123 || e1 !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=123/0", b1, e1); end
    checks++; if (b2 !== 511 || e2 !== 1'b0) begin failures++; $display("FAIL b2b_second got=%0d/%b exp=511/0", b2, e2); end
    checks++; if (l1 !== 10 || l2 !== 10) begin failures++; $display("FAIL b2b_latency got=%0d,%0d exp=10,10", l1, l2); end
    checks++; if (a2 - a1 !== 11) begin failures++; $display("FAIL b2b_accept_spacing got=%0d exp=11", a2 - a1); end
  endtask

  task automatic test_exhaustive;
    int b, l, a;
    bit e, s;
    for (int v = 0; v < 512; v++) begin
      run_one(v / 100, (v / 10) % 10, v % 10, b, e, l, s, a);
      checks++;
      if (b !== v || e !== 1'b0 || l !== 10 || s !== 1'b1) begin
        failures++;
        $display("FAIL roundtrip_%0d got bin=%0d err=%b lat=%0d quiet=%b exp bin=%0d err=0 lat=10 quiet=1",
                 v, b, e, l, s, v);
      end
    end
  endtask

  task automatic test_illegal;
    int hs[4] = '{5, 6, 0, 0};
    int ts[4] = '{1, 0, 10, 0};
    int us[4] = '{2, 0, 0, 15};
    int b, l, a;
    bit e, s;
    for (int i = 0; i < 4; i++) begin
      run_one(hs[i], ts[i], us[i], b, e, l, s, a);
      checks++;
      if (b !== 0 || e !== 1'b1 || l !== 10) begin
        failures++;
        $display("FAIL illegal_%0d_%0d_%0d got bin=%0d err=%b lat=%0d exp bin=0 err=1 lat=10",
                 hs[i], ts[i], us[i], b, e, l);
      end
    end
  endtask

  task automatic test_random;
    int h, t, u, b, l, a;
    bit e, s;
    for (int i = 0; i < 60; i++) begin
      h = $urandom_range(0, 7);
      t = $urandom_range(0, 15);
      u = $urandom_range(0, 15);
      run_one(h, t, u, b, e, l, s, a);
      checks++;
      if (b !== ref_bin(h, t, u) || e !== ref_err(h, t, u) || l !== 10) begin
        failures++;
        $display("FAIL random_%0d_%0d_%0d got bin=%0d err=%b lat=%0d exp bin=%0d err=%b lat=10",
                 h, t, u, b, e, l, ref_bin(h, t, u), ref_err(h, t, u));
      end
    end
  endtask

  task automatic test_hold_valid;
    int lat1 = -1, lat2 = -1, bin1 = -1, bin2 = -1, extra = 0, guard = 0;
    bit ready11 = 1'b0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid   = 1'b1;
    in_hundred = 3'd2;
    in_ten     = 4'd5;
    in_unit    = 4'd5;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_hundred = 3'd4;
        in_ten     = 4'd4;
        in_unit    = 4'd4;
      end
      if (k == 11) ready11 = in_ready;
      if (k == 12) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (lat1 < 0) begin lat1 = k; bin1 = int'(out_bin); end
        else if (lat2 < 0) begin lat2 = k; bin2 = int'(out_bin); end
        else extra++;
      end
    end
    checks++; if (lat1 !== 10 || bin1 !== 255) begin failures++; $display("FAIL hold_first got lat=%0d bin=%0d exp lat=10 bin=255", lat1, bin1); end
    checks++; if (ready11 !== 1'b1) begin failures++; $display("FAIL hold_ready_before_A11 got=%b exp=1", ready11); end
    checks++; if (lat2 !== 21 || bin2 !== 444) begin failures++; $display("FAIL hold_second got lat=%0d bin=%0d exp lat=21 bin=444", lat2, bin2); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL hold_extra_results got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort;
    int guard = 0, strobes = 0, b, l, a;
    bit e, s;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid   = 1'b1;
    in_hundred = 3'd3;
    in_ten     = 4'd0;
    in_unit    = 4'd7;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== 9'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_async_outputs got ready=%b valid=%b bin=%0d err=%b exp 1/0/0/0",
               in_ready, out_valid, out_bin, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", strobes); end
    run_one(0, 9, 9, b, e, l, s, a);
    checks++; if (b !== 99 || e !== 1'b0 || l !== 10) begin failures++; $display("FAIL after_abort got bin=%0d err=%b lat=%0d exp 99/0/10", b, e, l); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_exhaustive();
    test_illegal();
    test_random();
    test_hold_valid();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
